// File: rtl/dcache_pkg.sv
// Shared types and address-slicing helpers for the direct-mapped data cache.
package dcache_pkg;

  localparam int LINES_DEF  = 64;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int IDX_W      = $clog2(LINES_DEF);
  localparam int TAG_W      = ADDR_W_DEF - IDX_W - 2;

  typedef enum logic [1:0] {
    IDLE,
    RFILL,
    WRITE,
    WDONE
  } state_t;

  function automatic logic [IDX_W-1:0] idx_of(
    input logic [ADDR_W_DEF-1:0] a
  );
    return a[2 +: IDX_W];
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(
    input logic [ADDR_W_DEF-1:0] a
  );
    return a[ADDR_W_DEF-1 -: TAG_W];
  endfunction

  function automatic logic [1:0] off_of(
    input logic [ADDR_W_DEF-1:0] a
  );
    return a[1:0];
  endfunction

  function automatic logic [ADDR_W_DEF-1:0] word_addr(
    input logic [ADDR_W_DEF-1:0] a
  );
    return {a[ADDR_W_DEF-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage: asynchronous read, synchronous write.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int LINES  = 64,
  parameter int TAG_W  = 24,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(LINES)-1:0] idx,
  input  logic                     we,
  input  logic [TAG_W-1:0]         wtag,
  input  logic [DATA_W-1:0]        wdata,
  output logic                     valid,
  output logic [TAG_W-1:0]         tag,
  output logic [DATA_W-1:0]        data
);

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];

  assign valid = valid_q[idx];
  assign tag   = tag_q[idx];
  assign data  = data_q[idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[idx] <= 1'b1;
    end
  end

  // Data array is not reset; valid bits alone gate hits.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_q[idx]  <= wtag;
      data_q[idx] <= wdata;
    end
  end

endmodule

// File: rtl/data_cache_ctrl.sv
// Direct-mapped write-through, write-no-allocate data cache controller
// with a request/ready handshake towards main memory.
module data_cache_ctrl
  import dcache_pkg::*;
#(
  parameter int LINES  = 64,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int IW = $clog2(LINES);
  localparam int TW = ADDR_W - IW - 2;

  state_t            state;
  logic [IW-1:0]     idx;
  logic [TW-1:0]     tag;
  logic [ADDR_W-1:0] waddr;
  logic              line_valid;
  logic [TW-1:0]     line_tag;
  logic [DATA_W-1:0] line_data;
  logic              hit;
  logic              arr_we;
  logic [DATA_W-1:0] arr_wdata;
  logic              unused_off;

  assign idx        = addr[2 +: IW];
  assign tag        = addr[ADDR_W-1 -: TW];
  assign waddr      = {addr[ADDR_W-1:2], 2'b00};
  assign unused_off = ^addr[1:0];
  assign hit        = line_valid && (line_tag == tag);

  // Refill always allocates; a store only refreshes a line it hits.
  assign arr_we = !rst && mem_ready &&
                  ((state == RFILL) ||
                   ((state == WRITE) && hit));
  assign arr_wdata = (state == RFILL) ? mem_rdata : wdata;

  dcache_array #(
    .LINES  (LINES),
    .TAG_W  (TW),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .idx   (idx),
    .we    (arr_we),
    .wtag  (tag),
    .wdata (arr_wdata),
    .valid (line_valid),
    .tag   (line_tag),
    .data  (line_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (MemWrite) begin
            state <= WRITE;
          end else if (MemRead && !hit) begin
            state <= RFILL;
          end
        end
        RFILL: begin
          if (mem_ready) state <= IDLE;
        end
        WRITE: begin
          if (mem_ready) state <= WDONE;
        end
        WDONE: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    stall     = 1'b0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    rdata     = '0;
    unique case (1'b1)
      (state == IDLE): begin
        stall = MemWrite || (MemRead && !hit);
        if (MemRead && !MemWrite && hit) begin
          rdata = line_data;
        end
      end
      (state == RFILL): begin
        stall     = 1'b1;
        mem_rd_en = 1'b1;
        mem_addr  = waddr;
      end
      (state == WRITE): begin
        stall     = 1'b1;
        mem_wr_en = 1'b1;
        mem_addr  = waddr;
        mem_wdata = wdata;
      end
      (state == WDONE): begin
        stall = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Scoreboard bench for data_cache_ctrl with a variable-latency memory.
module tb_data_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  int lat = 1;
  int wait_cnt = 0;

  logic [31:0] mem_model [logic [31:0]];
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  data_cache_ctrl #(
    .LINES  (64),
    .ADDR_W (32),
    .DATA_W (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .stall     (stall),
    .mem_rd_en (mem_rd_en),
    .mem_wr_en (mem_wr_en),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  // Memory answers on the lat-th cycle a request is seen.
  always @(negedge clk) begin
    if (mem_rd_en || mem_wr_en) begin
      wait_cnt++;
      if (wait_cnt >= lat) begin
        mem_ready = 1'b1;
        if (mem_rd_en) mem_rdata = mem_model[mem_addr];
        else mem_model[mem_addr] = mem_wdata;
        wait_cnt = 0;
      end else begin
        mem_ready = 1'b0;
      end
    end else begin
      mem_ready = 1'b0;
      mem_rdata = '0;
      wait_cnt = 0;
    end
  end

  task automatic access(
    input bit          wr,
    input bit          rd_too,
    input logic [31:0] a,
    input logic [31:0] d,
    input int          lt,
    input int          exp_n,
    input string       nm
  );
    int n = 0;
    int rdc = 0;
    int wrc = 0;
    logic [31:0] seen_a = '0;
    logic [31:0] seen_d = '0;
    logic [31:0] exp_d;
    lat = lt;
    @(negedge clk);
    #1;
    MemRead = !wr || rd_too;
    MemWrite = wr;
    addr = a;
    wdata = d;
    if (!wr) exp_q.push_back(d);
    #1;
    while (stall && n < 64) begin
      if (mem_rd_en) begin rdc++; seen_a = mem_addr; end
      if (mem_wr_en) begin
        wrc++; seen_a = mem_addr; seen_d = mem_wdata;
      end
      n++;
      @(negedge clk);
      #1;
    end
    checks++;
    if (n !== exp_n) begin
      errors++;
      $display("FAIL %s stall_cycles: got %0d expected %0d", nm, n, exp_n);
    end
    checks++;
    if (rdc !== (wr ? 0 : (exp_n > 0 ? exp_n - 1 : 0))) begin
      errors++;
      $display("FAIL %s rd_cycles: got %0d", nm, rdc);
    end
    checks++;
    if (wrc !== (wr ? exp_n - 1 : 0)) begin
      errors++;
      $display("FAIL %s wr_cycles: got %0d", nm, wrc);
    end
    if (exp_n > 0) begin
      checks++;
      if (seen_a !== {a[31:2], 2'b00}) begin
        errors++;
        $display("FAIL %s mem_addr: got %h expected %h", nm, seen_a, {a[31:2], 2'b00});
      end
    end
    if (wr) begin
      checks++;
      if (seen_d !== d) begin
        errors++;
        $display("FAIL %s mem_wdata: got %h expected %h", nm, seen_d, d);
      end
      checks++;
      if (rdata !== 32'h0 || stall !== 1'b0) begin
        errors++;
        $display("FAIL %s wdone: rdata %h stall %b expected 0 0", nm, rdata, stall);
      end
    end else begin
      exp_d = exp_q.pop_front();
      checks++;
      if (rdata !== exp_d) begin
        errors++;
        $display("FAIL %s rdata: got %h expected %h", nm, rdata, exp_d);
      end
    end
    MemRead = 1'b0;
    MemWrite = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (stall !== 1'b0 || mem_rd_en !== 1'b0 || mem_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: stall %b rd %b wr %b expected 0 0 0", stall, mem_rd_en, mem_wr_en);
    end
    checks++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: addr %h wdata %h rdata %h expected 0", mem_addr, mem_wdata, rdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_read_miss;
    access(0, 0, 32'h100, 32'hDEADBEEF, 3, 4, "read_miss");
  endtask

  task automatic test_read_hit;
    access(0, 0, 32'h100, 32'hDEADBEEF, 1, 0, "read_hit");
    access(0, 0, 32'h100, 32'hDEADBEEF, 1, 0, "read_hit_b2b");
  endtask

  task automatic test_store_hit;
    access(1, 0, 32'h100, 32'h12345678, 1, 2, "store_hit");
    access(0, 0, 32'h100, 32'h12345678, 1, 0, "load_after_store");
  endtask

  task automatic test_store_miss;
    access(1, 0, 32'h200, 32'hCAFEF00D, 1, 2, "store_miss");
    access(0, 0, 32'h200, 32'hCAFEF00D, 1, 2, "load_no_alloc");
  endtask

  task automatic test_conflict;
    access(0, 0, 32'h100, 32'h12345678, 1, 2, "conf_100");
    access(0, 0, 32'h200, 32'hCAFEF00D, 1, 2, "conf_200");
    access(0, 0, 32'h100, 32'h12345678, 1, 2, "conf_100_again");
  endtask

  task automatic test_store_both;
    access(1, 1, 32'h104, 32'h0F0F0F0F, 2, 3, "store_both");
    access(0, 0, 32'h104, 32'h0F0F0F0F, 1, 2, "load_104");
  endtask

  task automatic test_reset_mid_fill;
    lat = 10;
    @(negedge clk);
    #1;
    MemRead = 1'b1;
    addr = 32'h108;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (mem_rd_en !== 1'b1) begin
      errors++;
      $display("FAIL midfill_req: got %b expected 1", mem_rd_en);
    end
    rst = 1'b1;
    MemRead = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (stall !== 1'b0 || mem_rd_en !== 1'b0 || mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL midfill_abort: stall %b rd %b addr %h expected 0 0 0", stall, mem_rd_en, mem_addr);
    end
    rst = 1'b0;
    access(0, 0, 32'h100, 32'h12345678, 1, 2, "post_reset_miss");
  endtask

  initial begin
    rst = 1'b1;
    MemRead = 1'b0;
    MemWrite = 1'b0;
    addr = '0;
    wdata = '0;
    mem_model[32'h100] = 32'hDEADBEEF;
    mem_model[32'h104] = 32'h11111111;
    mem_model[32'h108] = 32'h55AA55AA;
    mem_model[32'h200] = 32'h0BADF00D;
    test_reset();
    test_read_miss();
    test_read_hit();
    test_store_hit();
    test_store_miss();
    test_conflict();
    test_store_both();
    test_reset_mid_fill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_cache_ctrl.md
# data_cache_ctrl

Direct-mapped, write-through, write-no-allocate data cache controller that sits directly downstream of the control unit and ALU in the single-cycle RISC-V core. It consumes `MemRead`/`MemWrite`, the ALU byte address and the store data. Integer and FP loads/stores (`lw`/`sw`/`flw`/`fsw`) share this path. On a hit it returns load data in the same cycle. On a miss or any store it raises `stall` to freeze the PC and register-file writes while it runs a request/ready handshake with main memory.

## Interface
Parameters:
- `LINES`, 64: number of one-word cache lines; must be a power of 2.
- `ADDR_W`, 32: byte-address width.
- `DATA_W`, 32: word width.

Ports:
- `clk` input, 1 bit: the single clock.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `MemRead` input, 1 bit: load request from the control unit.
- `MemWrite` input, 1 bit: store request from the control unit.
- `addr` input, `ADDR_W` bits: byte address from the ALU; bits [1:0] are ignored.
- `wdata` input, `DATA_W` bits: store data (integer or FP register).
- `rdata` output, `DATA_W` bits: load data.
- `stall` output, 1 bit: core must hold PC and suppress register writeback.
- `mem_rd_en` output, 1 bit: main-memory read request.
- `mem_wr_en` output, 1 bit: main-memory write request.
- `mem_addr` output, `ADDR_W` bits: word-aligned memory address.
- `mem_wdata` output, `DATA_W` bits: memory write data.
- `mem_rdata` input, `DATA_W` bits: memory read data, valid with `mem_ready`.
- `mem_ready` input, 1 bit: memory completion, sampled every cycle a request is high.

## Operation
Address split:
- Index: `addr[2+IDX_W-1:2]`, where `IDX_W = log2(LINES)`.
- Tag: the remaining upper bits.
- Hit: the line's valid bit is set and its stored tag equals the address tag.

FSM states:
- **IDLE**
  - `MemWrite`: `stall=1`; next state WRITE.
  - `MemRead` and hit: `stall=0`, `rdata` = line data.
  - `MemRead` and miss: `stall=1`; next state RFILL.
  - No request: `stall=0`.
- **RFILL**
  - `stall=1`, `mem_rd_en=1`, `mem_addr={addr[ADDR_W-1:2],2'b00}`.
  - On `mem_ready`: write `mem_rdata`, the tag and `valid=1` into the line; next state IDLE. The retried access then hits.
- **WRITE**
  - `stall=1`, `mem_wr_en=1`, `mem_wdata=wdata`.
  - On `mem_ready`: if the address hits, update the line data (no allocate on miss); next state WDONE.
- **WDONE**
  - `stall=0` for exactly one cycle so the store instruction retires.
  - Next state IDLE unconditionally. No new access is evaluated in this cycle.

Boundary rules:
- `MemRead` and `MemWrite` both high: treated as a store.
- A store that misses leaves the cache contents unchanged.
- A store that hits keeps the line coherent with memory.
- Address and request are held stable by the stalled core; the controller does not latch them.
- `rdata` is 0 whenever the cycle is not IDLE with a read hit.
- Reset during RFILL or WRITE: abort, drop requests next edge, return to IDLE, clear all valid bits. The data array need not be cleared.

## Timing
Reset values (cycle after `rst` sampled high):
- State: IDLE.
- `stall`, `mem_rd_en`, `mem_wr_en`: 0.
- `mem_addr`, `mem_wdata`, `rdata`: 0.
- All valid bits: 0.

Latency and handshake:
- Read hit: zero added cycles; `stall` stays low.
- Read miss: `stall` is high for `1 + k` cycles, where k ≥ 1 is the number of cycles spent in RFILL including the `mem_ready` cycle. Data is returned in the following IDLE cycle. Zero-wait memory gives 2 stall cycles.
- Store: `stall` is high for `1 + k` cycles, then the WDONE cycle has `stall=0`.
- `stall` is combinational from state, request and hit. Outputs in RFILL/WRITE are Moore.
- A request stays asserted, with address and data constant, until the cycle `mem_ready=1` is sampled.
- `mem_ready` is ignored when no request is high.

## Structure
Shared package `dcache_pkg`:
- State enum: IDLE, RFILL, WRITE, WDONE.
- `IDX_W` and `TAG_W` derived widths.
- Tag/index/offset slice helper functions.

Sub-module `dcache_array`:
- Valid, tag and data storage.
- Asynchronous read, synchronous write.
- Valid bits cleared on `rst`.
- Instantiated once by `data_cache_ctrl`.

## Test plan
1. Reset, then load from `0x100` with memory returning `0xDEADBEEF` after 3 cycles. Required: `stall` high for 4 cycles, `mem_addr=0x100`, then `rdata=0xDEADBEEF` with `stall=0`.
2. Repeat the load from `0x100`. Required: hit, `stall=0`, no `mem_rd_en`, `rdata=0xDEADBEEF`.
3. Store `0x12345678` to `0x100` (hit), then load `0x100`. Required: `mem_wr_en` pulse, one WDONE cycle, then the load hits with `rdata=0x12345678`.
4. Store to `0x200` (miss), then load `0x200`. Required: the store does not allocate, so the load misses and refills.
5. Conflict, with `LINES=64`:
   - Load `0x100` (line 0), then load `0x200`. Since `0x200` also maps to line 0, it evicts `0x100`.
   - Load `0x100` again. Required: miss.
   - Zero-wait memory. Required: exactly 2 stall cycles for each miss.
6. Assert `rst` mid-RFILL. Required: next cycle IDLE, `mem_rd_en=0`, `stall=0`, and a prior hit address now misses.
